// File: rtl/fc_gen_pkg.sv
// Shared types and saturating arithmetic helpers for the FC layer engine.
package fc_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WLOAD,
        ST_XLOAD,
        ST_MAC,
        ST_OUT
    } state_e;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    function automatic longint sat_clamp(input longint v, input int w);
        if (v > sat_max(w)) return sat_max(w);
        if (v < sat_min(w)) return sat_min(w);
        return v;
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input int w);
        return sat_clamp(a + b, w);
    endfunction

endpackage

// File: rtl/fc_sat_mac.sv
// One MAC lane: operand register -> saturated product register -> saturated accumulator.
module fc_sat_mac
    import fc_gen_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] w_i,
    output logic [WIDTH-1:0] acc_o
);
    logic signed [WIDTH-1:0]   x_q, w_q, prod_q, prod_d, acc_q, acc_d;
    logic                      op_vld_q, prod_vld_q;
    logic signed [2*WIDTH-1:0] prod_full;

    assign prod_full = (2*WIDTH)'(x_q) * (2*WIDTH)'(w_q);
    assign prod_d    = WIDTH'(sat_clamp(longint'(prod_full), WIDTH));
    assign acc_d     = WIDTH'(sat_add(longint'(acc_q), longint'(prod_q), WIDTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q        <= '0;
            w_q        <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            op_vld_q   <= 1'b0;
            prod_vld_q <= 1'b0;
        end else begin
            op_vld_q   <= en_i;
            prod_vld_q <= op_vld_q;
            if (en_i) begin
                x_q <= x_i;
                w_q <= w_i;
            end
            if (op_vld_q) prod_q <= prod_d;
            if (clr_i) acc_q <= '0;
            else if (prod_vld_q) acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/fc_layer_gen.sv
// Fully-connected layer engine: weights streamed into P banks, x vector streamed in,
// P saturating MAC lanes produce M results group by group with optional ReLU.
module fc_layer_gen
    import fc_gen_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int P     = 1,
    parameter int RELU  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             weight_valid,
    output logic             weight_ready,
    input  logic [WIDTH-1:0] weight_data,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [WIDTH-1:0] input_data,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [WIDTH-1:0] output_data
);
    localparam int G  = M / P;
    localparam int BD = G * N;
    localparam int XW = $clog2(N);
    localparam int CW = $clog2(N + 4);
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int LW = (P > 1) ? $clog2(P) : 1;
    localparam int AW = (BD > 1) ? $clog2(BD) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(N - 1);
    localparam logic [CW-1:0] ISSUE_N  = CW'(N);
    localparam logic [CW-1:0] MAC_LAST = CW'(N + 3);
    localparam logic [GW-1:0] G_LAST   = GW'(G - 1);
    localparam logic [LW-1:0] L_LAST   = LW'(P - 1);
    localparam logic [AW-1:0] N_A      = AW'(N);

    state_e          state_q, state_d;
    logic            w_loaded_q, w_loaded_d;
    logic [XW-1:0]   w_col_q, w_col_d;
    logic [LW-1:0]   w_bank_q, w_bank_d;
    logic [GW-1:0]   w_grp_q, w_grp_d;
    logic [XW-1:0]   x_idx_q, x_idx_d;
    logic [CW-1:0]   mac_cnt_q, mac_cnt_d;
    logic [GW-1:0]   g_q, g_d;
    logic [LW-1:0]   j_q, j_d;
    logic            w_we, x_we, mac_en, mac_clr, res_we;

    logic [WIDTH-1:0] x_mem [N];
    logic [WIDTH-1:0] w_mem [P][BD];
    logic [WIDTH-1:0] res_q [P];
    logic [WIDTH-1:0] acc   [P];
    logic [AW-1:0]    w_wr_addr, w_rd_addr;
    logic [XW-1:0]    x_rd_addr;

    assign w_wr_addr = AW'(w_grp_q) * N_A + AW'(w_col_q);
    assign x_rd_addr = mac_cnt_q[XW-1:0];
    assign w_rd_addr = AW'(g_q) * N_A + AW'(x_rd_addr);

    always_ff @(posedge clk) begin
        if (w_we) w_mem[w_bank_q][w_wr_addr] <= weight_data;
        if (x_we) x_mem[x_idx_q] <= input_data;
    end

    for (genvar l = 0; l < P; l++) begin : g_lane
        fc_sat_mac #(.WIDTH(WIDTH)) u_mac (
            .clk   (clk),
            .reset (reset),
            .clr_i (mac_clr),
            .en_i  (mac_en),
            .x_i   (x_mem[x_rd_addr]),
            .w_i   (w_mem[l][w_rd_addr]),
            .acc_o (acc[l])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < P; l++) res_q[l] <= '0;
        end else if (res_we) begin
            for (int l = 0; l < P; l++)
                res_q[l] <= (RELU != 0 && acc[l][WIDTH-1]) ? '0 : acc[l];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            w_loaded_q <= 1'b0;
            w_col_q    <= '0;
            w_bank_q   <= '0;
            w_grp_q    <= '0;
            x_idx_q    <= '0;
            mac_cnt_q  <= '0;
            g_q        <= '0;
            j_q        <= '0;
        end else begin
            state_q    <= state_d;
            w_loaded_q <= w_loaded_d;
            w_col_q    <= w_col_d;
            w_bank_q   <= w_bank_d;
            w_grp_q    <= w_grp_d;
            x_idx_q    <= x_idx_d;
            mac_cnt_q  <= mac_cnt_d;
            g_q        <= g_d;
            j_q        <= j_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        w_loaded_d   = w_loaded_q;
        w_col_d      = w_col_q;
        w_bank_d     = w_bank_q;
        w_grp_d      = w_grp_q;
        x_idx_d      = x_idx_q;
        mac_cnt_d    = mac_cnt_q;
        g_d          = g_q;
        j_d          = j_q;
        weight_ready = 1'b0;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        output_data  = '0;
        w_we         = 1'b0;
        x_we         = 1'b0;
        mac_en       = 1'b0;
        mac_clr      = 1'b0;
        res_we       = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE, ST_WLOAD: begin
                    weight_ready = 1'b1;
                    input_ready  = (state_q == ST_IDLE) && w_loaded_q && !weight_valid;
                    if (weight_valid) begin
                        w_we    = 1'b1;
                        state_d = ST_WLOAD;
                        w_col_d = w_col_q + XW'(1);
                        // Row-major stream: rows rotate over banks, then advance bank depth.
                        if (w_col_q == X_LAST) begin
                            w_col_d  = '0;
                            w_bank_d = w_bank_q + LW'(1);
                            if (w_bank_q == L_LAST) begin
                                w_bank_d = '0;
                                w_grp_d  = w_grp_q + GW'(1);
                                if (w_grp_q == G_LAST) begin
                                    w_grp_d    = '0;
                                    w_loaded_d = 1'b1;
                                    state_d    = ST_IDLE;
                                end
                            end
                        end
                    end else if (input_ready && input_valid) begin
                        x_we    = 1'b1;
                        x_idx_d = x_idx_q + XW'(1);
                        state_d = ST_XLOAD;
                    end
                end
                ST_XLOAD: begin
                    input_ready = 1'b1;
                    if (input_valid) begin
                        x_we    = 1'b1;
                        x_idx_d = x_idx_q + XW'(1);
                        if (x_idx_q == X_LAST) begin
                            x_idx_d   = '0;
                            g_d       = '0;
                            mac_cnt_d = '0;
                            state_d   = ST_MAC;
                        end
                    end
                end
                ST_MAC: begin
                    // N issue cycles, then the pipeline drains before results are latched.
                    mac_en    = (mac_cnt_q < ISSUE_N);
                    mac_cnt_d = mac_cnt_q + CW'(1);
                    if (mac_cnt_q == MAC_LAST) begin
                        res_we    = 1'b1;
                        mac_clr   = 1'b1;
                        mac_cnt_d = '0;
                        j_d       = '0;
                        state_d   = ST_OUT;
                    end
                end
                ST_OUT: begin
                    output_valid = 1'b1;
                    output_data  = res_q[j_q];
                    if (output_ready) begin
                        j_d = j_q + LW'(1);
                        if (j_q == L_LAST) begin
                            j_d = '0;
                            if (g_q == G_LAST) begin
                                g_d     = '0;
                                state_d = ST_IDLE;
                            end else begin
                                g_d     = g_q + GW'(1);
                                state_d = ST_MAC;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_gen.sv
// Scoreboard bench: stimulus pushes hand-computed results, negedge monitors pop and compare.
module tb_fc_layer_gen;
    logic clk = 1'b0;
    logic reset;
    logic wv, iv, ordy;
    logic [15:0] wd, id;
    logic wr_a, ir_a, ov_a, wr_b, ir_b, ov_b;
    logic signed [15:0] od_a, od_b;
    logic wv_c, iv_c, ordy_c;
    logic [15:0] wd_c, id_c;
    logic wr_c, ir_c, ov_c;
    logic signed [15:0] od_c;

    int n_pass = 0;
    int n_total = 0;
    logic signed [15:0] exp_a[$];
    logic signed [15:0] exp_b[$];
    logic signed [15:0] exp_c[$];

    always #5 clk = ~clk;

    fc_layer_gen #(.WIDTH(16), .M(4), .N(4), .P(2), .RELU(1)) dut_a (
        .clk(clk), .reset(reset), .weight_valid(wv), .weight_ready(wr_a), .weight_data(wd),
        .input_valid(iv), .input_ready(ir_a), .input_data(id),
        .output_valid(ov_a), .output_ready(ordy), .output_data(od_a));

    fc_layer_gen #(.WIDTH(16), .M(4), .N(4), .P(2), .RELU(0)) dut_b (
        .clk(clk), .reset(reset), .weight_valid(wv), .weight_ready(wr_b), .weight_data(wd),
        .input_valid(iv), .input_ready(ir_b), .input_data(id),
        .output_valid(ov_b), .output_ready(ordy), .output_data(od_b));

    fc_layer_gen #(.WIDTH(16), .M(1), .N(4), .P(1), .RELU(0)) dut_c (
        .clk(clk), .reset(reset), .weight_valid(wv_c), .weight_ready(wr_c), .weight_data(wd_c),
        .input_valid(iv_c), .input_ready(ir_c), .input_data(id_c),
        .output_valid(ov_c), .output_ready(ordy_c), .output_data(od_c));

    task automatic chk(input string nm, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    always @(negedge clk) begin
        if (ov_a && ordy) begin
            if (exp_a.size() == 0) begin
                n_total++;
                $display("FAIL out_a: got unexpected output %0d, required none", od_a);
            end else chk("out_a", od_a, exp_a.pop_front());
        end
        if (ov_b && ordy) begin
            if (exp_b.size() == 0) begin
                n_total++;
                $display("FAIL out_b: got unexpected output %0d, required none", od_b);
            end else chk("out_b", od_b, exp_b.pop_front());
        end
        if (ov_c && ordy_c) begin
            if (exp_c.size() == 0) begin
                n_total++;
                $display("FAIL out_c: got unexpected output %0d, required none", od_c);
            end else chk("out_c", od_c, exp_c.pop_front());
        end
    end

    function automatic logic [15:0] wval(input int r, input int c);
        case (r)
            0:       return 16'd1;
            1:       return 16'hFFFF;
            2:       return 16'(c + 1);
            default: return 16'd0;
        endcase
    endfunction

    task automatic push_w(input bit sel, input logic [15:0] d);
        int t = 0;
        if (sel) begin wv_c = 1'b1; wd_c = d; end
        else begin wv = 1'b1; wd = d; end
        @(negedge clk);
        while (!(sel ? wr_c : wr_a) && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin n_total++; $display("FAIL w_timeout: got no weight_ready, required 1"); end
        @(posedge clk); #1;
        if (sel) wv_c = 1'b0; else wv = 1'b0;
    endtask

    task automatic push_x(input bit sel, input logic [15:0] d);
        int t = 0;
        if (sel) begin iv_c = 1'b1; id_c = d; end
        else begin iv = 1'b1; id = d; end
        @(negedge clk);
        while (!(sel ? ir_c : ir_a) && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin n_total++; $display("FAIL x_timeout: got no input_ready, required 1"); end
        @(posedge clk); #1;
        if (sel) iv_c = 1'b0; else iv = 1'b0;
    endtask

    task automatic load_ab(input int first);
        for (int k = first; k < 16; k++) push_w(1'b0, wval(k / 4, k % 4));
    endtask

    task automatic vec1_ab();
        exp_a.push_back(16'sd10); exp_a.push_back(16'sd0);
        exp_a.push_back(16'sd30); exp_a.push_back(16'sd0);
        exp_b.push_back(16'sd10); exp_b.push_back(-16'sd10);
        exp_b.push_back(16'sd30); exp_b.push_back(16'sd0);
        for (int i = 0; i < 4; i++) push_x(1'b0, 16'(i + 1));
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((exp_a.size() + exp_b.size() + exp_c.size()) != 0 && t < 300) begin
            @(posedge clk); t++;
        end
        #1;
        chk(nm, exp_a.size() + exp_b.size() + exp_c.size(), 0);
    endtask

    initial begin
        int k;
        reset = 1'b1; wv = 1'b0; iv = 1'b0; ordy = 1'b1; wd = '0; id = '0;
        wv_c = 1'b0; iv_c = 1'b0; ordy_c = 1'b1; wd_c = '0; id_c = '0;
        @(negedge clk);
        chk("rst_wready", wr_a, 0);
        chk("rst_ovalid", ov_a, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_wready", wr_a, 1);
        chk("idle_iready", ir_a, 0);

        @(posedge clk); #1 iv = 1'b1; id = 16'h0055;
        repeat (3) begin @(negedge clk); chk("noweight_iready", ir_a, 0); end
        @(posedge clk); #1 iv = 1'b0;

        load_ab(0);
        ordy = 1'b0;
        vec1_ab();
        k = 0;
        @(negedge clk);
        while (!ov_a && k < 40) begin @(posedge clk); k++; @(negedge clk); end
        chk("first_latency", k, 8);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("bp_valid", ov_a, 1);
            chk("bp_data_a", od_a, 10);
            chk("bp_data_b", od_b, 10);
        end
        @(posedge clk); #1 ordy = 1'b1;
        drain("vec1_drain");

        exp_a.push_back(16'sd0);  exp_a.push_back(16'sd2);
        exp_a.push_back(16'sd0);  exp_a.push_back(16'sd0);
        exp_b.push_back(-16'sd2); exp_b.push_back(16'sd2);
        exp_b.push_back(-16'sd7); exp_b.push_back(16'sd0);
        push_x(1'b0, 16'hFFFF); push_x(1'b0, 16'd0);
        push_x(1'b0, 16'd2);    push_x(1'b0, 16'hFFFD);
        drain("vec2_drain");

        wv = 1'b1; wd = wval(0, 0); iv = 1'b1; id = 16'h0100;
        @(negedge clk);
        chk("prio_wready", wr_a, 1);
        chk("prio_iready", ir_a, 0);
        @(posedge clk); #1 wv = 1'b0; iv = 1'b0;
        @(negedge clk);
        chk("prio_wload_wready", wr_a, 1);
        chk("prio_wload_iready", ir_a, 0);
        @(posedge clk); #1;
        load_ab(1);
        vec1_ab();
        drain("reload_drain");

        for (int i = 0; i < 4; i++) push_x(1'b0, 16'(i + 1));
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("midmac_rst_ovalid", ov_a, 0);
        chk("midmac_rst_wready", wr_a, 0);
        @(posedge clk); #1 reset = 1'b0; iv = 1'b1; id = 16'd1;
        @(negedge clk);
        chk("post_rst_ovalid", ov_a, 0);
        chk("post_rst_wready", wr_a, 1);
        chk("post_rst_iready", ir_a, 0);
        @(posedge clk); #1 iv = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        load_ab(0);
        vec1_ab();
        drain("post_rst_drain");

        for (int i = 0; i < 4; i++) push_w(1'b1, 16'h7FFF);
        exp_c.push_back(16'sh7FFF);
        for (int i = 0; i < 4; i++) push_x(1'b1, 16'd2);
        drain("sat_pos_drain");
        for (int i = 0; i < 4; i++) push_w(1'b1, 16'h8000);
        exp_c.push_back(-16'sd32768);
        for (int i = 0; i < 4; i++) push_x(1'b1, 16'd2);
        drain("sat_neg_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000, required completion");
        $fatal(1);
    end
endmodule
